// File: rtl/multicycle_ctrl.sv
// Main controller for the multi-cycle MIPS-subset CPU: walks one instruction at a time through fetch/decode/execute/memory/writeback.
// Latency: 3 cycles (branch/jump), 4 (R-type, I-type, sw), 5 (lw) with zero-wait memory; +1 per memory wait cycle.
// Backpressure: FETCH, MEM_RD and MEM_WR hold while mem_ready_i=0; mem_ready_i is ignored in every other state.
//
// Ports:
//   clk_i, rst_i            clock and synchronous active-low reset (all outputs forced to 0 while rst_i=0)
//   instr_op_i              opcode of the instruction register, sampled in DECODE
//   mem_ready_i             shared memory port finishes the current access this cycle
//   PCWrite_o..ALU_op_o     datapath mux selects, write enables and ALU operation code
//   instr_done_o            one-cycle pulse in the last cycle of each instruction
//   trap_o                  illegal opcode seen; held until reset
//   state_o                 current FSM state (debug)

module multicycle_ctrl #(
    parameter int ST_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [5:0]      instr_op_i,
    input  logic            mem_ready_i,
    output logic            PCWrite_o,
    output logic            PCWriteCond_o,
    output logic            BranchType_o,
    output logic [1:0]      PCSource_o,
    output logic            IorD_o,
    output logic            MemRead_o,
    output logic            MemWrite_o,
    output logic            IRWrite_o,
    output logic [1:0]      RegDst_o,
    output logic [1:0]      MemToReg_o,
    output logic            RegWrite_o,
    output logic            ALUSrcA_o,
    output logic [1:0]      ALUSrcB_o,
    output logic [3:0]      ALU_op_o,
    output logic            instr_done_o,
    output logic            trap_o,
    output logic [ST_W-1:0] state_o
);

    localparam logic [ST_W-1:0] FETCH    = ST_W'(0);
    localparam logic [ST_W-1:0] DECODE   = ST_W'(1);
    localparam logic [ST_W-1:0] MEM_ADDR = ST_W'(2);
    localparam logic [ST_W-1:0] MEM_RD   = ST_W'(3);
    localparam logic [ST_W-1:0] MEM_WB   = ST_W'(4);
    localparam logic [ST_W-1:0] MEM_WR   = ST_W'(5);
    localparam logic [ST_W-1:0] EXEC_R   = ST_W'(6);
    localparam logic [ST_W-1:0] R_WB     = ST_W'(7);
    localparam logic [ST_W-1:0] BRANCH   = ST_W'(8);
    localparam logic [ST_W-1:0] JUMP     = ST_W'(9);
    localparam logic [ST_W-1:0] EXEC_I   = ST_W'(10);
    localparam logic [ST_W-1:0] I_WB     = ST_W'(11);
    localparam logic [ST_W-1:0] TRAP     = ST_W'(12);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [ST_W-1:0] state_q, state_d;
    logic [5:0]      op_q;

    logic       pc_write, pc_write_cond, branch_type, iord, mem_read, mem_write;
    logic       ir_write, reg_write, alu_src_a, instr_done, trap;
    logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_b;
    logic [3:0] alu_op;

    function automatic logic [ST_W-1:0] decode_next(input logic [5:0] op);
        case (op)
            OP_RTYPE:                         return EXEC_R;
            OP_LW, OP_SW:                     return MEM_ADDR;
            OP_BEQ, OP_BNE:                   return BRANCH;
            OP_J, OP_JAL:                     return JUMP;
            OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI: return EXEC_I;
            default:                          return TRAP;
        endcase
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= FETCH;
            op_q    <= 6'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                op_q <= instr_op_i;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_type   = 1'b0;
        pc_source     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 4'b0000;
        instr_done    = 1'b0;
        trap          = 1'b0;
        case (state_q)
            FETCH: begin
                // PC+4 computed alongside the read; IR and PC only load once memory answers
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 4'b0100;
                ir_write  = mem_ready_i;
                pc_write  = mem_ready_i;
                if (mem_ready_i) state_d = DECODE;
            end
            DECODE: begin
                // speculative branch target into ALUOut
                alu_src_b = 2'b11;
                alu_op    = 4'b0100;
                state_d   = decode_next(instr_op_i);
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 4'b0100;
                state_d   = (op_q == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready_i) state_d = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready_i) begin
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 4'b0010;
                state_d   = R_WB;
            end
            R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_type   = (op_q == OP_BNE);
                alu_op        = (op_q == OP_BNE) ? 4'b0001 : 4'b0011;
                instr_done    = 1'b1;
                state_d       = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                // jal links the PC that FETCH already advanced
                if (op_q == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
                state_d = FETCH;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_q)
                    OP_SLTIU: alu_op = 4'b0111;
                    OP_LUI:   alu_op = 4'b0101;
                    OP_ORI:   alu_op = 4'b0110;
                    default:  alu_op = 4'b0100;
                endcase
                state_d = I_WB;
            end
            I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Outputs are gated by rst_i so no enable can leak during the reset cycle itself.
    assign PCWrite_o     = rst_i & pc_write;
    assign PCWriteCond_o = rst_i & pc_write_cond;
    assign BranchType_o  = rst_i & branch_type;
    assign PCSource_o    = rst_i ? pc_source : 2'b00;
    assign IorD_o        = rst_i & iord;
    assign MemRead_o     = rst_i & mem_read;
    assign MemWrite_o    = rst_i & mem_write;
    assign IRWrite_o     = rst_i & ir_write;
    assign RegDst_o      = rst_i ? reg_dst : 2'b00;
    assign MemToReg_o    = rst_i ? mem_to_reg : 2'b00;
    assign RegWrite_o    = rst_i & reg_write;
    assign ALUSrcA_o     = rst_i & alu_src_a;
    assign ALUSrcB_o     = rst_i ? alu_src_b : 2'b00;
    assign ALU_op_o      = rst_i ? alu_op : 4'b0000;
    assign instr_done_o  = rst_i & instr_done;
    assign trap_o        = rst_i & trap;
    assign state_o       = rst_i ? state_q : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios then randomized opcodes, memory waits and resets.
// Each cycle the full output vector is compared against a plan-based model of the instruction's phases.
// Instruction latency is checked at every instr_done pulse against base latency plus observed wait cycles.

module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [5:0] instr_op_i;
    logic       mem_ready_i;
    logic       PCWrite_o, PCWriteCond_o, BranchType_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
    logic       RegWrite_o, ALUSrcA_o, instr_done_o, trap_o;
    logic [1:0] PCSource_o, RegDst_o, MemToReg_o, ALUSrcB_o;
    logic [3:0] ALU_op_o, state_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.ST_W(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
        .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .BranchType_o(BranchType_o),
        .PCSource_o(PCSource_o), .IorD_o(IorD_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .IRWrite_o(IRWrite_o), .RegDst_o(RegDst_o), .MemToReg_o(MemToReg_o), .RegWrite_o(RegWrite_o),
        .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALU_op_o(ALU_op_o),
        .instr_done_o(instr_done_o), .trap_o(trap_o), .state_o(state_o)
    );

    wire [26:0] dut_vec = {PCWrite_o, PCWriteCond_o, BranchType_o, PCSource_o, IorD_o, MemRead_o,
                           MemWrite_o, IRWrite_o, RegDst_o, MemToReg_o, RegWrite_o, ALUSrcA_o,
                           ALUSrcB_o, ALU_op_o, instr_done_o, trap_o, state_o};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected output vector for a phase of the instruction, straight from the control table.
    function automatic logic [26:0] exp_vec(input int st, input logic [5:0] op, input logic rdy);
        logic pcw = 0, pcwc = 0, bt = 0, iord = 0, mr = 0, mw = 0, irw = 0, rw = 0, sa = 0, done = 0, trp = 0;
        logic [1:0] pcs = 0, rd = 0, m2r = 0, sb = 0;
        logic [3:0] aop = 0;
        case (st)
            0:  begin mr = 1; sb = 2'b01; aop = 4'b0100; irw = rdy; pcw = rdy; end
            1:  begin sb = 2'b11; aop = 4'b0100; end
            2:  begin sa = 1; sb = 2'b10; aop = 4'b0100; end
            3:  begin iord = 1; mr = 1; end
            4:  begin rw = 1; m2r = 2'b01; done = 1; end
            5:  begin iord = 1; mw = 1; done = rdy; end
            6:  begin sa = 1; aop = 4'b0010; end
            7:  begin rw = 1; rd = 2'b01; done = 1; end
            8:  begin sa = 1; pcwc = 1; pcs = 2'b01; done = 1;
                      bt = (op == 6'b000101); aop = (op == 6'b000101) ? 4'b0001 : 4'b0011; end
            9:  begin pcw = 1; pcs = 2'b10; done = 1;
                      if (op == 6'b000011) begin rw = 1; rd = 2'b10; m2r = 2'b10; end end
            10: begin sa = 1; sb = 2'b10;
                      aop = (op == 6'b001011) ? 4'b0111 : (op == 6'b001111) ? 4'b0101 :
                            (op == 6'b001101) ? 4'b0110 : 4'b0100; end
            11: begin rw = 1; done = 1; end
            default: trp = 1;
        endcase
        return {pcw, pcwc, bt, pcs, iord, mr, mw, irw, rd, m2r, rw, sa, sb, aop, done, trp, 4'(st)};
    endfunction

    function automatic int base_lat(input logic [5:0] op);
        case (op)
            6'b100011:                       return 5;
            6'b000100, 6'b000101,
            6'b000010, 6'b000011:            return 3;
            default:                         return 4;
        endcase
    endfunction

    // Model: the list of phases this instruction walks through, and our position in it.
    int         plan[$];
    int         idx;
    logic [5:0] mop;
    int         icyc;
    int         nwait;

    task automatic model_reset();
        plan  = '{0, 1};
        idx   = 0;
        icyc  = 0;
        nwait = 0;
    endtask

    task automatic step(input logic r, input logic [5:0] op, input logic rdy, input string tag);
        int cur;
        @(negedge clk);
        rst_i = r; instr_op_i = op; mem_ready_i = rdy;
        #2;
        if (!r) begin
            chk(tag, {5'b0, dut_vec}, 32'd0);
            model_reset();
            mop = 6'b0;
            return;
        end
        cur = plan[idx];
        chk(tag, {5'b0, dut_vec}, {5'b0, exp_vec(cur, mop, rdy)});
        if (cur == 12) return;
        icyc++;
        if (cur == 1) begin
            mop = op;
            case (op)
                6'b000000:                                 plan.push_back(6);
                6'b100011, 6'b101011:                      plan.push_back(2);
                6'b000100, 6'b000101:                      plan.push_back(8);
                6'b000010, 6'b000011:                      plan.push_back(9);
                6'b001000, 6'b001011, 6'b001111, 6'b001101: plan.push_back(10);
                default:                                   plan.push_back(12);
            endcase
            case (op)
                6'b000000:                                 plan.push_back(7);
                6'b100011:                                 begin plan.push_back(3); plan.push_back(4); end
                6'b101011:                                 plan.push_back(5);
                6'b001000, 6'b001011, 6'b001111, 6'b001101: plan.push_back(11);
                default: ;
            endcase
        end
        if (instr_done_o) chk({tag, "_latency"}, icyc, base_lat(mop) + nwait);
        if ((cur == 0 || cur == 3 || cur == 5) && !rdy) begin
            nwait++;
            return;
        end
        idx++;
        if (idx == plan.size()) model_reset();
    endtask

    task automatic run_op(input logic [5:0] op, input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, (i == 1) ? op : 6'($urandom), 1'b1, tag);
    endtask

    logic [5:0] legal_ops [11] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
                                   6'b000011, 6'b001000, 6'b001011, 6'b001111, 6'b001101};

    initial begin
        rst_i = 1'b0; instr_op_i = 6'b0; mem_ready_i = 1'b0;
        model_reset();
        mop = 6'b0;

        // reset held two cycles, then an R-type with zero-wait memory
        step(1'b0, 6'b0, 1'b1, "reset");
        step(1'b0, 6'b0, 1'b1, "reset");
        for (int i = 0; i < 4; i++) step(1'b1, 6'b000000, 1'b1, "rtype");

        // lw with two fetch waits and three read waits
        step(1'b1, 6'b100011, 1'b0, "lw_fetch_wait");
        step(1'b1, 6'b100011, 1'b0, "lw_fetch_wait");
        step(1'b1, 6'b100011, 1'b1, "lw_fetch");
        step(1'b1, 6'b100011, 1'b1, "lw_decode");
        step(1'b1, 6'b111111, 1'b1, "lw_addr");
        for (int i = 0; i < 3; i++) step(1'b1, 6'b000000, 1'b0, "lw_rd_wait");
        step(1'b1, 6'b000000, 1'b1, "lw_rd");
        step(1'b1, 6'b000000, 1'b0, "lw_wb");

        run_op(6'b000101, 3, "bne");
        run_op(6'b000100, 3, "beq");
        run_op(6'b000011, 3, "jal");
        run_op(6'b000010, 3, "j");
        run_op(6'b001011, 4, "sltiu");
        run_op(6'b001111, 4, "lui");

        // illegal opcode: sticky trap regardless of mem_ready_i
        step(1'b1, 6'b111111, 1'b1, "trap_fetch");
        step(1'b1, 6'b111111, 1'b1, "trap_decode");
        for (int i = 0; i < 20; i++) step(1'b1, 6'($urandom), 1'(i), "trap_hold");
        chk("trap_sticky", {31'b0, trap_o}, 32'd1);
        step(1'b0, 6'b0, 1'b1, "trap_reset");
        step(1'b1, 6'b0, 1'b0, "trap_exit");
        chk("trap_exit_state", {28'b0, state_o}, 32'd0);
        chk("trap_exit_flag", {31'b0, trap_o}, 32'd0);

        // sw stalled in MEM_WR, then reset: MemWrite drops in the reset cycle
        step(1'b1, 6'b101011, 1'b1, "sw_fetch");
        step(1'b1, 6'b101011, 1'b1, "sw_decode");
        step(1'b1, 6'b101011, 1'b1, "sw_addr");
        step(1'b1, 6'b101011, 1'b0, "sw_wr_wait");
        chk("sw_memwrite_held", {31'b0, MemWrite_o}, 32'd1);
        step(1'b0, 6'b101011, 1'b0, "sw_reset");
        chk("sw_rst_memwrite", {31'b0, MemWrite_o}, 32'd0);
        step(1'b1, 6'b101011, 1'b0, "sw_after_reset");
        chk("sw_after_reset_state", {28'b0, state_o}, 32'd0);

        // randomized opcodes, memory waits and occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 99) < 3) ? 6'($urandom) : legal_ops[$urandom_range(0, 10)];
            step(($urandom_range(0, 59) != 0), op, ($urandom_range(0, 2) != 0), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
